// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX/MEM pipeline register with elastic valid/ready handshake.
//
// Holds one instruction in a main entry (drives all outputs) and one in a
// skid entry, so the stage can absorb a single extra instruction while MEM
// back-pressures.  flush drops every held and incoming instruction.  Memory
// and write-back controls (and pc_src) are forced to 0 when no instruction is
// presented, so bubbles can never write memory, the register file or the PC.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous kill of held and incoming entries
//   in_valid/in_ready upstream handshake (in_ready = no skid entry held)
//   ctlwb_in, ctlm_in write-back controls; memory controls {memwrite,memread,branch}
//   adder_in, aluzero_in, aluout_in, readdat2_in, muxout_in  EX results
//   out_valid/out_ready downstream handshake
//   wb_ctlout, branch, memread, memwrite  masked controls
//   add_result, alu_result, rdata2out, zero, five_bit_muxout  data fields
//   pc_src            branch AND zero AND out_valid
module ex_mem_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int WB_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   ctlwb_in,
    input  logic [2:0]        ctlm_in,
    input  logic [DATA_W-1:0] adder_in,
    input  logic              aluzero_in,
    input  logic [DATA_W-1:0] aluout_in,
    input  logic [DATA_W-1:0] readdat2_in,
    input  logic [REG_W-1:0]  muxout_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   wb_ctlout,
    output logic              branch,
    output logic              memread,
    output logic              memwrite,
    output logic [DATA_W-1:0] add_result,
    output logic              zero,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] rdata2out,
    output logic [REG_W-1:0]  five_bit_muxout,
    output logic              pc_src
);

    typedef struct packed {
        logic [WB_W-1:0]   wb;
        logic [2:0]        m;
        logic [DATA_W-1:0] add;
        logic              zero;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rd2;
        logic [REG_W-1:0]  rd;
    } entry_t;

    entry_t in_e;
    entry_t main_e;
    entry_t skid_e;
    logic   main_valid;
    logic   skid_valid;
    logic   accept_in;
    logic   advance;

    always_comb begin
        in_e      = '{wb: ctlwb_in, m: ctlm_in, add: adder_in, zero: aluzero_in,
                      alu: aluout_in, rd2: readdat2_in, rd: muxout_in};
        in_ready  = ~skid_valid;
        accept_in = in_valid & in_ready;
        advance   = ~main_valid | out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_e     <= '0;
            skid_e     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            // Data fields keep stale values; only the valid bits matter.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (advance) begin
            if (skid_valid) begin
                main_e     <= skid_e;
                main_valid <= 1'b1;
                if (accept_in) begin
                    skid_e <= in_e;
                end else begin
                    skid_valid <= 1'b0;
                end
            end else begin
                main_e     <= in_e;
                main_valid <= accept_in;
            end
        end else if (accept_in) begin
            skid_e     <= in_e;
            skid_valid <= 1'b1;
        end
    end

    always_comb begin
        out_valid       = main_valid;
        wb_ctlout       = main_valid ? main_e.wb : '0;
        branch          = main_valid & main_e.m[0];
        memread         = main_valid & main_e.m[1];
        memwrite        = main_valid & main_e.m[2];
        pc_src          = main_valid & main_e.m[0] & main_e.zero;
        add_result      = main_e.add;
        zero            = main_e.zero;
        alu_result      = main_e.alu;
        rdata2out       = main_e.rd2;
        five_bit_muxout = main_e.rd;
    end

endmodule
